// File: rtl/pll_lock_sequencer.sv
// Sequences the rPLL through reset, lock acquisition and lock qualification,
// and holds the system reset until the PLL has been stably locked.
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 27000,
    parameter int LOCK_STABLE_CYCLES  = 2700,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 16
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       pll_ready,
    output logic       fail,
    output logic [1:0] retry_count,
    output logic [7:0] lost_lock_cnt
);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sync;
    logic [1:0]       r_retry;
    logic [7:0]       r_lost;
    logic             r_pll_reset;
    logic             r_sys_reset;
    logic             r_pll_ready;
    logic             r_fail;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [1:0]       w_retry_next;
    logic [7:0]       w_lost_next;
    logic             w_lock_s;

    // pll_lock is asynchronous to clkin; only the second flop is trusted.
    assign w_lock_s = r_sync[1];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_retry_next = r_retry;
        w_lost_next  = r_lost;
        case (r_state)
            ST_RESET_PLL: begin
                if (r_cnt == RST_LAST) begin
                    w_state_next = ST_WAIT_LOCK;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_next = ST_STABLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_cnt_next = '0;
                    if (r_retry == RETRY_MAX) begin
                        w_state_next = ST_FAIL;
                    end else begin
                        w_state_next = ST_RESET_PLL;
                        w_retry_next = r_retry + 2'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            ST_STABLE: begin
                // A single dropped sample restarts both qualification and timeout.
                if (!w_lock_s) begin
                    w_state_next = ST_WAIT_LOCK;
                    w_cnt_next   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!w_lock_s) begin
                    w_state_next = ST_RESET_PLL;
                    w_cnt_next   = '0;
                    w_retry_next = 2'd0;
                    w_lost_next  = (r_lost == 8'hFF) ? r_lost : r_lost + 8'd1;
                end else if (relock_req) begin
                    w_state_next = ST_RESET_PLL;
                    w_cnt_next   = '0;
                    w_retry_next = 2'd0;
                end
            end
            ST_FAIL: begin
                if (relock_req) begin
                    w_state_next = ST_RESET_PLL;
                    w_cnt_next   = '0;
                    w_retry_next = 2'd0;
                end
            end
            default: begin
                w_state_next = ST_RESET_PLL;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change with r_state.
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state     <= ST_RESET_PLL;
            r_cnt       <= '0;
            r_sync      <= 2'b00;
            r_retry     <= 2'd0;
            r_lost      <= 8'd0;
            r_pll_reset <= 1'b1;
            r_sys_reset <= 1'b1;
            r_pll_ready <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], pll_lock};
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_retry     <= w_retry_next;
            r_lost      <= w_lost_next;
            r_pll_reset <= (w_state_next == ST_RESET_PLL) || (w_state_next == ST_FAIL);
            r_sys_reset <= (w_state_next != ST_RUN);
            r_pll_ready <= (w_state_next == ST_RUN);
            r_fail      <= (w_state_next == ST_FAIL);
        end
    end

    assign pll_reset     = r_pll_reset;
    assign sys_reset     = r_sys_reset;
    assign pll_ready     = r_pll_ready;
    assign fail          = r_fail;
    assign retry_count   = r_retry;
    assign lost_lock_cnt = r_lost;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters
// (pulse 4, timeout 20, stable 8, 2 retries).
module tb_pll_lock_sequencer;

    logic       clkin = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       relock_req;
    logic       pll_reset;
    logic       sys_reset;
    logic       pll_ready;
    logic       fail;
    logic [1:0] retry_count;
    logic [7:0] lost_lock_cnt;

    int checks = 0;
    int errors = 0;
    int falls;
    logic prev_rst;

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_TIMEOUT_CYCLES(20),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2),
        .CNT_W              (16)
    ) dut (
        .clkin        (clkin),
        .rst          (rst),
        .pll_lock     (pll_lock),
        .relock_req   (relock_req),
        .pll_reset    (pll_reset),
        .sys_reset    (sys_reset),
        .pll_ready    (pll_ready),
        .fail         (fail),
        .retry_count  (retry_count),
        .lost_lock_cnt(lost_lock_cnt)
    );

    always #5 clkin = ~clkin;

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input logic val, input int max, input string tag);
        int n;
        n = 0;
        while (pll_ready !== val && n < max) begin
            tick();
            n++;
        end
        chk(tag, 32'(pll_ready), 32'(val));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pll_lock = 1'b0; relock_req = 1'b0;
        repeat (3) tick();
        chk("rst_pll_reset", 32'(pll_reset), 1);
        chk("rst_sys_reset", 32'(sys_reset), 1);
        chk("rst_ready",     32'(pll_ready), 0);
        chk("rst_fail",      32'(fail), 0);
        chk("rst_retry",     32'(retry_count), 0);
        chk("rst_lost",      32'(lost_lock_cnt), 0);

        // First lock: 4-cycle pll_reset pulse, lock raised 5 cycles after it ends.
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("pulse_hi", 32'(pll_reset), 1);
        end
        tick();
        chk("pulse_lo", 32'(pll_reset), 0);
        repeat (5) tick();
        pll_lock = 1'b1;
        repeat (10) tick();
        chk("lock_ready_e9", 32'(pll_ready), 0);
        chk("lock_sys_e9",   32'(sys_reset), 1);
        tick();
        chk("lock_ready_e10", 32'(pll_ready), 1);
        chk("lock_sys_e10",   32'(sys_reset), 0);
        chk("lock_retry",     32'(retry_count), 0);

        // Lock loss in RUN for 3 sampled cycles.
        pll_lock = 1'b0;
        tick(); tick();
        chk("drop_sys_d1",   32'(sys_reset), 0);
        chk("drop_ready_d1", 32'(pll_ready), 1);
        tick();
        chk("drop_sys_d2",   32'(sys_reset), 1);
        chk("drop_ready_d2", 32'(pll_ready), 0);
        chk("drop_lost",     32'(lost_lock_cnt), 1);
        chk("drop_pll_rst",  32'(pll_reset), 1);
        pll_lock = 1'b1;
        repeat (3) tick();
        chk("drop_pulse_hi", 32'(pll_reset), 1);
        tick();
        chk("drop_pulse_lo", 32'(pll_reset), 0);
        wait_ready(1'b1, 20, "drop_relock");

        // relock_req alone in RUN.
        pll_lock = 1'b0; relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        chk("req_ready",   32'(pll_ready), 0);
        chk("req_pll_rst", 32'(pll_reset), 1);
        chk("req_lost",    32'(lost_lock_cnt), 1);
        repeat (4) tick();
        chk("req_wait", 32'(pll_reset), 0);
        // relock_req in WAIT_LOCK is ignored.
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        chk("wait_req_ignored", 32'(pll_reset), 0);
        chk("wait_req_sys",     32'(sys_reset), 1);

        // Lock glitch during STABLE.
        pll_lock = 1'b1;
        repeat (5) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        repeat (10) tick();
        chk("glitch_ready_g15", 32'(pll_ready), 0);
        tick();
        chk("glitch_ready_g16", 32'(pll_ready), 1);
        chk("glitch_retry",     32'(retry_count), 0);

        // Lock loss and relock_req in the same cycle.
        pll_lock = 1'b0;
        tick(); tick();
        chk("both_ready_h1", 32'(pll_ready), 1);
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        chk("both_pll_rst", 32'(pll_reset), 1);
        chk("both_lost",    32'(lost_lock_cnt), 2);
        pll_lock = 1'b1;
        wait_ready(1'b1, 40, "both_relock");

        // Reach WAIT_LOCK with retry 1 and counter 10, then assert rst.
        pll_lock = 1'b0; relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        chk("q_lost", 32'(lost_lock_cnt), 2);
        repeat (38) tick();
        chk("q_retry",   32'(retry_count), 1);
        chk("q_pll_rst", 32'(pll_reset), 0);
        rst = 1'b1;
        tick();
        chk("mid_rst_pll_rst", 32'(pll_reset), 1);
        chk("mid_rst_retry",   32'(retry_count), 0);
        chk("mid_rst_lost",    32'(lost_lock_cnt), 0);
        chk("mid_rst_sys",     32'(sys_reset), 1);

        // Lock never arrives: three attempts, then FAIL at cycle 72.
        rst = 1'b0;
        prev_rst = pll_reset;
        falls = 0;
        for (int i = 1; i <= 71; i++) begin
            tick();
            if (prev_rst && !pll_reset) falls++;
            prev_rst = pll_reset;
        end
        chk("fail_c71",    32'(fail), 0);
        chk("fail_pulses", 32'(falls), 3);
        tick();
        chk("fail_c72",       32'(fail), 1);
        chk("fail_retry",     32'(retry_count), 2);
        chk("fail_pll_rst",   32'(pll_reset), 1);
        repeat (5) tick();
        chk("fail_hold",      32'(fail), 1);
        chk("fail_hold_prst", 32'(pll_reset), 1);
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        chk("unfail_fail",  32'(fail), 0);
        chk("unfail_retry", 32'(retry_count), 0);
        chk("unfail_prst",  32'(pll_reset), 1);
        repeat (3) tick();
        chk("unfail_pulse_hi", 32'(pll_reset), 1);
        tick();
        chk("unfail_pulse_lo", 32'(pll_reset), 0);

        // 256 lock losses: counter saturates at 255.
        for (int i = 1; i <= 256; i++) begin
            pll_lock = 1'b1;
            wait_ready(1'b1, 60, "sat_up");
            pll_lock = 1'b0;
            wait_ready(1'b0, 10, "sat_down");
            if (i == 255) chk("sat_255", 32'(lost_lock_cnt), 255);
        end
        chk("sat_hold", 32'(lost_lock_cnt), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
